alu_request_arbiter: RTL and testbench
======================================

# alu_request_arbiter

Sequencing front end for the shared 32-bit ALU. Two requesters (e.g. the execute stage and a micro-coded helper) submit ALU operations over valid/ready handshakes. The block arbitrates round-robin, registers the operands that drive the ALU, and validates the opcode. It captures the ALU result and returns it over a single response channel tagged with the requester ID.

## Interface
Parameters:
- WIDTH, 32, operand/result width
- OPW, 5, opcode width

Ports:
- clock  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- req0_valid / req1_valid  in  1  request pending from requester 0 / 1
- req0_ready / req1_ready  out  1  request accepted this cycle
- req0_op / req1_op  in  OPW  ALU opcode
- req0_a, req0_b, req0_num / req1_a, req1_b, req1_num  in  WIDTH  operands and shift/rotate amount
- alu_opcode  out  OPW  registered opcode to ALU
- alu_a, alu_b, alu_num  out  WIDTH  registered operands to ALU
- alu_result  in  WIDTH  combinational ALU result
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer takes response
- rsp_id  out  1  requester that issued the op
- rsp_result  out  WIDTH  captured result
- rsp_err  out  1  opcode was not a legal ALU opcode

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any req valid, grant exactly one: the requester not granted last, when both are valid; otherwise the sole valid one.
  - Granted reqN_ready=1 (combinational from valids, IDLE only). Operands latch into alu_* registers. Go to EXEC.
  - Non-granted ready=0.
- EXEC (one cycle):
  - Capture alu_result into rsp_result, set rsp_id and rsp_err, set rsp_valid=1. Go to RESP.
- RESP:
  - Hold all rsp_* stable until rsp_ready=1.
  - On handshake: rsp_valid=0 next cycle, go to IDLE.
- Legal opcodes: 0 AND, 1 OR, 2 XOR, 3 NOT, 8 SHL, 9 SHR, 10 SAR, 11 ROL.
- Illegal opcode: the op is still sequenced; rsp_err=1, rsp_result=0 (forced, independent of alu_result).
- alu_num: bits [4:0] from request, bits [WIDTH-1:5] forced to 0.
- Round-robin pointer (last_grant) updates only on an accepted request.
- Requesters hold valid and payload stable until ready; the block does not buffer a dropped request.

## Timing
- Reset values:
  - state=IDLE, last_grant=1 (requester 0 wins the first tie).
  - alu_opcode, alu_a, alu_b, alu_num, rsp_result = 0.
  - rsp_valid, rsp_err, rsp_id = 0.
  - req ready outputs 0 unless IDLE with a valid.
- Accept at cycle T. alu_* updated at T+1. rsp_valid=1 at T+2.
- Response handshake at cycle R → IDLE at R+1. The earliest next accept is R+1.
- Minimum 3 cycles per op.
- rsp_ready held high in EXEC has no effect; only RESP consumes it.
- rsp_ready=1 asserted in the first RESP cycle → single-cycle response.
- Both valids asserted at reset release → requester 0 granted first.
- Reset asserted mid-EXEC or mid-RESP: in-flight op discarded and no response emitted; all registers return to reset values immediately.
- alu_* registers hold their last value outside EXEC; they change only on accept.

## Structure
- Shared include alu_defs.vh: opcode localparams (OP_AND … OP_ROL), OPW, the legal-opcode check function, FSM state encodings.
- One sub-module: rr_arbiter2 (2-input round-robin grant with pointer update on accept).
- Registers and FSM in the top module.

## Test plan
- Single op, req0: op=0, a=0xF0F0F0F0, b=0xFF00FF00 → req0_ready at T, rsp_valid at T+2, rsp_result=0xF000F000, rsp_id=0, rsp_err=0.
- Tie arbitration: both valid continuously, rsp_ready=1 → grants alternate 0,1,0,1; rsp_id sequence 0,1,0,1.
- Shift masking: op=8, a=1, num=0x00000021 → alu_num=1, rsp_result=0x00000002.
- Illegal opcode: op=4, a=5, b=7 → rsp_err=1, rsp_result=0, next op proceeds normally.
- Backpressure: rsp_ready low 5 cycles → rsp_* stable, both req ready=0 throughout; release → IDLE next cycle.
- Reset mid-op: assert reset_n=0 in EXEC → rsp_valid never rises, all outputs 0; after release, req1 alone valid is granted.

Source files
------------

// File: rtl/alu_request_arbiter_pkg.sv
// Shared definitions for the ALU request arbiter: opcode encodings, the
// legal-opcode check and the sequencing FSM state type.
package alu_request_arbiter_pkg;

  localparam int unsigned OpW = 5;

  localparam logic [OpW-1:0] OpAnd = 5'd0;
  localparam logic [OpW-1:0] OpOr  = 5'd1;
  localparam logic [OpW-1:0] OpXor = 5'd2;
  localparam logic [OpW-1:0] OpNot = 5'd3;
  localparam logic [OpW-1:0] OpShl = 5'd8;
  localparam logic [OpW-1:0] OpShr = 5'd9;
  localparam logic [OpW-1:0] OpSar = 5'd10;
  localparam logic [OpW-1:0] OpRol = 5'd11;

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StResp
  } state_e;

  function automatic logic is_legal_op(input logic [OpW-1:0] op);
    logic legal;
    case (op)
      OpAnd, OpOr, OpXor, OpNot, OpShl, OpShr, OpSar, OpRol: legal = 1'b1;
      default:                                               legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin arbiter.
//   clk_i, rst_ni : clock, async active-low reset
//   req_i[1:0]    : request lines
//   en_i          : arbitration enabled this cycle (grants are zero otherwise)
//   gnt_o[1:0]    : one-hot grant; a grant is also the acceptance, so the
//                   pointer advances whenever a grant is issued
module rr_arbiter2 (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  input  logic       en_i,
  output logic [1:0] gnt_o
);

  // Index of the requester granted last; resets to 1 so requester 0 wins the
  // first tie.
  logic last_grant_q, last_grant_d;

  always_comb begin
    gnt_o        = 2'b00;
    last_grant_d = last_grant_q;
    if (en_i) begin
      unique case (req_i)
        2'b01:   gnt_o = 2'b01;
        2'b10:   gnt_o = 2'b10;
        2'b11:   gnt_o = last_grant_q ? 2'b01 : 2'b10;
        default: gnt_o = 2'b00;
      endcase
      if (|gnt_o) begin
        last_grant_d = gnt_o[1];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/alu_request_arbiter.sv
// Sequencing front end for the shared ALU. Two requesters are arbitrated
// round-robin; the granted operands are registered towards the ALU, the ALU
// result is captured one cycle later and returned on a single tagged response
// channel.
//   clock, reset_n             : clock, async active-low reset
//   reqN_valid/ready           : request handshakes (ready only in idle)
//   reqN_op/a/b/num            : request payloads
//   alu_opcode/a/b/num         : registered ALU operands
//   alu_result                 : combinational ALU result
//   rsp_valid/ready            : response handshake
//   rsp_id/result/err          : response payload
module alu_request_arbiter
  import alu_request_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned OPW   = OpW
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [OPW-1:0]   req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [WIDTH-1:0] req0_num,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [OPW-1:0]   req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [WIDTH-1:0] req1_num,
  output logic [OPW-1:0]   alu_opcode,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [WIDTH-1:0] alu_num,
  input  logic [WIDTH-1:0] alu_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_err
);

  state_e           state_q, state_d;
  logic [OPW-1:0]   op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, num_q, num_d;
  logic             id_q, id_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_id_q, rsp_id_d;
  logic             rsp_err_q, rsp_err_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;

  logic [1:0] gnt;
  logic       in_idle;
  logic       op_legal;

  assign in_idle  = (state_q == StIdle);
  assign op_legal = is_legal_op(op_q);

  rr_arbiter2 u_arb (
    .clk_i  (clock),
    .rst_ni (reset_n),
    .req_i  ({req1_valid, req0_valid}),
    .en_i   (in_idle),
    .gnt_o  (gnt)
  );

  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    num_d        = num_q;
    id_d         = id_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_err_d    = rsp_err_q;
    rsp_result_d = rsp_result_q;

    unique case (state_q)
      StIdle: begin
        if (|gnt) begin
          op_d    = gnt[1] ? req1_op : req0_op;
          a_d     = gnt[1] ? req1_a  : req0_a;
          b_d     = gnt[1] ? req1_b  : req0_b;
          // Only the low five bits form a shift amount; the rest is zeroed.
          num_d   = {{(WIDTH-5){1'b0}}, (gnt[1] ? req1_num[4:0] : req0_num[4:0])};
          id_d    = gnt[1];
          state_d = StExec;
        end
      end
      StExec: begin
        // Illegal opcodes still complete, but never leak the ALU output.
        rsp_result_d = op_legal ? alu_result : '0;
        rsp_err_d    = ~op_legal;
        rsp_id_d     = id_q;
        rsp_valid_d  = 1'b1;
        state_d      = StResp;
      end
      StResp: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      num_q        <= '0;
      id_q         <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_result_q <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      num_q        <= num_d;
      id_q         <= id_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_err_q    <= rsp_err_d;
      rsp_result_q <= rsp_result_d;
    end
  end

  assign alu_opcode = op_q;
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_num    = num_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_err    = rsp_err_q;
  assign rsp_result = rsp_result_q;

endmodule

// File: tb/tb_alu_request_arbiter.sv
module tb_alu_request_arbiter;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [4:0]  req0_op, req1_op;
  logic [31:0] req0_a, req0_b, req0_num, req1_a, req1_b, req1_num;
  logic [4:0]  alu_opcode;
  logic [31:0] alu_a, alu_b, alu_num;
  logic [31:0] alu_result;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [31:0] rsp_result;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  alu_request_arbiter #(.WIDTH(32), .OPW(5)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_num   (req0_num),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_num   (req1_num),
    .alu_opcode (alu_opcode),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_num    (alu_num),
    .alu_result (alu_result),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_err    (rsp_err)
  );

  // Stand-in ALU; illegal opcodes yield a marker the DUT must suppress.
  always_comb begin
    case (alu_opcode)
      5'd0:    alu_result = alu_a & alu_b;
      5'd1:    alu_result = alu_a | alu_b;
      5'd2:    alu_result = alu_a ^ alu_b;
      5'd3:    alu_result = ~alu_a;
      5'd8:    alu_result = alu_a << alu_num[4:0];
      5'd9:    alu_result = alu_a >> alu_num[4:0];
      5'd10:   alu_result = $unsigned($signed(alu_a) >>> alu_num[4:0]);
      5'd11:   alu_result = (alu_a << alu_num[4:0]) | (alu_a >> (6'd32 - {1'b0, alu_num[4:0]}));
      default: alu_result = 32'hDEAD_BEEF;
    endcase
  end

  task automatic issue(input int id, input logic [4:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] num);
    if (id == 0) begin
      req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b; req0_num = num;
    end else begin
      req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b; req1_num = num;
    end
  endtask

  task automatic drop();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; drop(); rsp_ready = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err: got %b expected 0", rsp_err); end
    checks++; if (rsp_id !== 1'b0) begin errors++; $display("FAIL reset_rsp_id: got %b expected 0", rsp_id); end
    checks++; if (rsp_result !== 32'h0) begin errors++; $display("FAIL reset_rsp_result: got %h expected 0", rsp_result); end
    checks++; if ({alu_opcode, alu_a, alu_b, alu_num} !== '0) begin errors++; $display("FAIL reset_alu_regs: got %h %h %h %h expected all 0", alu_opcode, alu_a, alu_b, alu_num); end
    checks++; if ({req0_ready, req1_ready} !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b expected 00", {req0_ready, req1_ready}); end
  endtask

  task automatic test_tie();
    logic [31:0] exp_res;
    reset_n = 1'b0;
    issue(0, 5'd1, 32'h1, 32'h2, 32'h0);
    issue(1, 5'd2, 32'hF, 32'h3, 32'h0);
    rsp_ready = 1'b1;
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      exp_res = (i % 2 == 0) ? 32'h3 : 32'hC;
      checks++; if ({req1_ready, req0_ready} !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin errors++; $display("FAIL tie_grant[%0d]: got r1r0=%b%b expected %s", i, req1_ready, req0_ready, (i % 2 == 0) ? "01" : "10"); end
      @(negedge clock);
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL tie_exec_valid[%0d]: got %b expected 0", i, rsp_valid); end
      @(negedge clock);
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== (i % 2 == 1) || rsp_result !== exp_res) begin errors++; $display("FAIL tie_rsp[%0d]: got v=%b id=%b res=%h expected v=1 id=%0d res=%h", i, rsp_valid, rsp_id, rsp_result, i % 2, exp_res); end
      @(negedge clock);
    end
    drop(); rsp_ready = 1'b0;
  endtask

  task automatic test_single();
    issue(0, 5'd0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0);
    #1;
    checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin errors++; $display("FAIL single_ready: got r0=%b r1=%b expected r0=1 r1=0", req0_ready, req1_ready); end
    @(negedge clock);
    checks++; if (alu_a !== 32'hF0F0_F0F0 || alu_b !== 32'hFF00_FF00 || alu_opcode !== 5'd0) begin errors++; $display("FAIL single_alu_regs: got op=%h a=%h b=%h expected op=0 a=f0f0f0f0 b=ff00ff00", alu_opcode, alu_a, alu_b); end
    checks++; if (req0_ready !== 1'b0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL single_exec: got ready=%b v=%b expected 0 0", req0_ready, rsp_valid); end
    drop();
    @(negedge clock);
    checks++; if (rsp_valid !== 1'b1 || rsp_result !== 32'hF000_F000 || rsp_id !== 1'b0 || rsp_err !== 1'b0) begin errors++; $display("FAIL single_rsp: got v=%b res=%h id=%b err=%b expected v=1 res=f000f000 id=0 err=0", rsp_valid, rsp_result, rsp_id, rsp_err); end
    rsp_ready = 1'b1;
    @(negedge clock);
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_rsp_drop: got %b expected 0", rsp_valid); end
    rsp_ready = 1'b0;
  endtask

  task automatic test_shift();
    issue(0, 5'd8, 32'h1, 32'h0, 32'h21);
    @(negedge clock);
    checks++; if (alu_num !== 32'h1) begin errors++; $display("FAIL shift_num_mask: got %h expected 00000001", alu_num); end
    drop();
    @(negedge clock);
    checks++; if (rsp_result !== 32'h2 || rsp_err !== 1'b0) begin errors++; $display("FAIL shift_result: got res=%h err=%b expected res=00000002 err=0", rsp_result, rsp_err); end
    rsp_ready = 1'b1;
    @(negedge clock);
    rsp_ready = 1'b0;
  endtask

  task automatic test_illegal();
    issue(1, 5'd4, 32'h5, 32'h7, 32'h0);
    @(negedge clock);
    drop();
    @(negedge clock);
    checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_result !== 32'h0 || rsp_id !== 1'b1) begin errors++; $display("FAIL illegal_rsp: got v=%b err=%b res=%h id=%b expected v=1 err=1 res=0 id=1", rsp_valid, rsp_err, rsp_result, rsp_id); end
    rsp_ready = 1'b1;
    @(negedge clock);
    rsp_ready = 1'b0;
    issue(1, 5'd3, 32'h0, 32'h0, 32'h0);
    @(negedge clock);
    drop();
    @(negedge clock);
    checks++; if (rsp_err !== 1'b0 || rsp_result !== 32'hFFFF_FFFF) begin errors++; $display("FAIL illegal_next_op: got err=%b res=%h expected err=0 res=ffffffff", rsp_err, rsp_result); end
    rsp_ready = 1'b1;
    @(negedge clock);
    rsp_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    issue(0, 5'd10, 32'h8000_0000, 32'h0, 32'h4);
    @(negedge clock);
    drop();
    @(negedge clock);
    issue(0, 5'd0, 32'h1, 32'h1, 32'h0);
    issue(1, 5'd0, 32'h2, 32'h2, 32'h0);
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (rsp_valid !== 1'b1 || rsp_result !== 32'hF800_0000 || rsp_id !== 1'b0 || rsp_err !== 1'b0) begin errors++; $display("FAIL bp_hold[%0d]: got v=%b res=%h id=%b err=%b expected v=1 res=f8000000 id=0 err=0", i, rsp_valid, rsp_result, rsp_id, rsp_err); end
      checks++; if ({req1_ready, req0_ready} !== 2'b00 || alu_a !== 32'h8000_0000) begin errors++; $display("FAIL bp_ready_alu[%0d]: got r=%b%b alu_a=%h expected r=00 alu_a=80000000", i, req1_ready, req0_ready, alu_a); end
      @(negedge clock);
    end
    rsp_ready = 1'b1;
    @(negedge clock);
    #1;
    checks++; if (rsp_valid !== 1'b0 || {req1_ready, req0_ready} !== 2'b10) begin errors++; $display("FAIL bp_release: got v=%b r=%b%b expected v=0 r=10", rsp_valid, req1_ready, req0_ready); end
    drop();
    rsp_ready = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_reset_mid_op();
    issue(0, 5'd0, 32'hFFFF, 32'hFF, 32'h1F);
    @(negedge clock);
    drop();
    reset_n = 1'b0;
    #1;
    checks++; if ({alu_opcode, alu_a, alu_b, alu_num} !== '0 || rsp_result !== 32'h0 || {rsp_valid, rsp_err, rsp_id} !== 3'b000) begin errors++; $display("FAIL midreset_outputs: got op=%h a=%h b=%h n=%h res=%h v/e/id=%b%b%b expected all 0", alu_opcode, alu_a, alu_b, alu_num, rsp_result, rsp_valid, rsp_err, rsp_id); end
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL midreset_no_rsp[%0d]: got %b expected 0", i, rsp_valid); end
    end
    issue(1, 5'd1, 32'h10, 32'h01, 32'h0);
    #1;
    checks++; if ({req1_ready, req0_ready} !== 2'b10) begin errors++; $display("FAIL midreset_req1_grant: got r=%b%b expected 10", req1_ready, req0_ready); end
    @(negedge clock);
    drop();
    @(negedge clock);
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_result !== 32'h11) begin errors++; $display("FAIL midreset_req1_rsp: got v=%b id=%b res=%h expected v=1 id=1 res=00000011", rsp_valid, rsp_id, rsp_result); end
    rsp_ready = 1'b1;
    @(negedge clock);
    rsp_ready = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    rsp_ready = 1'b0;
    req0_valid = 1'b0; req0_op = '0; req0_a = '0; req0_b = '0; req0_num = '0;
    req1_valid = 1'b0; req1_op = '0; req1_a = '0; req1_b = '0; req1_num = '0;
    test_reset();
    test_tie();
    test_single();
    test_shift();
    test_illegal();
    test_backpressure();
    test_reset_mid_op();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
